oled_cmd_sequencer: RTL and testbench

OLED_CMD_SEQUENCER -- requirements
Module: oled_cmd_sequencer

---
 rtl/oled_cmd_sequencer_pkg.sv | 59 +++++
 rtl/oled_cmd_sequencer_if.sv | 14 +
 rtl/oled_cmd_sequencer_rom.sv | 21 ++
 rtl/oled_cmd_sequencer.sv | 139 +++++++++++++
 tb/tb_oled_cmd_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_cmd_sequencer_pkg.sv
// Shared definitions for the OLED command sequencer: ROM word layout,
// ROM image, sequence base/length tables and the FSM state type.
// No ports; imported by the sequencer, its ROM and the bench.
package oled_seq_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = BYTE_W + 2;

   // ROM word: {is_delay, dc, payload}. Delay words wait payload*DELAY_UNIT cycles.
   typedef struct packed {
      logic              is_delay;
      logic              dc;
      logic [BYTE_W-1:0] payload;
   } rom_word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_ROM,
      ST_SEND,
      ST_DELAY,
      ST_FIN
   } seq_state_t;

   localparam int unsigned ROM_USED = 32;

   // 0x00: panel init (24 cmds, 100-tick delay, display-on AF)
   // 0x1A: set-window (column 0..127, page 0..7)
   localparam logic [WORD_W-1:0] ROM_IMAGE [ROM_USED] = '{
      10'h0AE, 10'h0D5, 10'h0F0, 10'h0A8, 10'h03F, 10'h0D3, 10'h000, 10'h040,
      10'h0A1, 10'h0C8, 10'h0DA, 10'h012, 10'h081, 10'h0CF, 10'h0D9, 10'h0F1,
      10'h0DB, 10'h030, 10'h0A4, 10'h0A6, 10'h08D, 10'h014, 10'h020, 10'h000,
      10'h264, 10'h0AF,
      10'h021, 10'h000, 10'h07F, 10'h022, 10'h000, 10'h007
   };

   localparam int unsigned NUM_TABLE_SEQ = 2;
   localparam int SEQ_BASE [NUM_TABLE_SEQ] = '{'h00, 'h1A};
   localparam int SEQ_LEN  [NUM_TABLE_SEQ] = '{26, 6};

   function automatic rom_word_t rom_lookup(input int unsigned addr);
      logic [4:0] idx;
      idx = addr[4:0];
      if (addr < ROM_USED) return rom_word_t'(ROM_IMAGE[idx]);
      return '0;
   endfunction

   // Sequences present in NUM_SEQ but absent from the table behave as empty.
   function automatic int seq_base(input int unsigned k);
      if (k < NUM_TABLE_SEQ) return SEQ_BASE[k[0]];
      return 0;
   endfunction

   function automatic int seq_len(input int unsigned k);
      if (k < NUM_TABLE_SEQ) return SEQ_LEN[k[0]];
      return 0;
   endfunction

endpackage

// File: rtl/oled_cmd_sequencer_if.sv
// Byte handshake between the sequencer and the display serialiser.
// tx_valid/tx_data/tx_dc: byte offered (dc 0 = command, 1 = data)
// tx_ready: serialiser takes the byte when tx_valid && tx_ready
interface oled_cmd_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_dc;
   logic              tx_ready;

   modport master (output tx_valid, output tx_data, output tx_dc, input tx_ready);
   modport slave  (input tx_valid, input tx_data, input tx_dc, output tx_ready);
endinterface

// File: rtl/oled_cmd_sequencer_rom.sv
// Command ROM with registered read: data for addr_i appears the cycle after.
// clk: clock   addr_i: word address   rdata_o: registered ROM word
module oled_cmd_rom
   import oled_seq_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr_i,
   output rom_word_t         rdata_o
);

   rom_word_t rdata_q;

   always_ff @(posedge clk) begin
      rdata_q <= rom_lookup(32'(addr_i));
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/oled_cmd_sequencer.sv
// Plays a selected command sequence from ROM out to the OLED serialiser.
// clk/rst: clock and sync active-high reset
// start/seq_sel: run request and sequence index
// busy/done/err: running flag, end pulse, bad-index pulse (with done)
// tx: byte handshake toward the serialiser
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | ROM address presented
// WAIT_ROM | ROM word returns, decoded into SEND or DELAY
// SEND     | byte offered until tx_ready
// DELAY    | counting payload*DELAY_UNIT cycles
// FIN      | one-cycle done (and err) pulse
module oled_cmd_sequencer
   import oled_seq_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 8,
   parameter int NUM_SEQ    = 2,
   parameter int DELAY_UNIT = 1000,
   localparam int SEL_W     = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SEL_W-1:0]      seq_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   oled_cmd_sequencer_if.master  tx
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
   localparam logic [DLY_W-1:0] DU_V = DLY_W'(DELAY_UNIT);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              dc_q, dc_d;
   logic              err_q, err_d;
   logic              step;
   logic [31:0]       sel_ext;
   logic              sel_bad;
   logic [CNT_W-1:0]  sel_len;
   rom_word_t         rom_rd;

   oled_cmd_rom #(.ADDR_W(ADDR_W)) u_rom (
      .clk     (clk),
      .addr_i  (ptr_q),
      .rdata_o (rom_rd)
   );

   assign sel_ext = 32'(seq_sel);
   assign sel_bad = (sel_ext >= 32'(NUM_SEQ));
   assign sel_len = CNT_W'(seq_len(sel_ext));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      data_d  = data_q;
      dc_d    = dc_q;
      err_d   = err_q;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_d = sel_bad;
               if (sel_bad || (sel_len == '0)) begin
                  state_d = ST_FIN;
               end else begin
                  ptr_d   = ADDR_W'(seq_base(sel_ext));
                  cnt_d   = sel_len;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FETCH:    state_d = ST_WAIT_ROM;
         ST_WAIT_ROM: begin
            if (rom_rd.is_delay) begin
               dly_d   = DLY_W'(rom_rd.payload) * DU_V;
               state_d = ST_DELAY;
            end else begin
               data_d  = DATA_W'(rom_rd.payload);
               dc_d    = rom_rd.dc;
               state_d = ST_SEND;
            end
         end
         ST_SEND:  step = tx.tx_ready;
         ST_DELAY: begin
            // a zero-length delay still occupies this state for one cycle
            if (dly_q <= DLY_W'(1)) step = 1'b1;
            else                    dly_d = dly_q - DLY_W'(1);
         end
         ST_FIN: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (step) begin
         ptr_d   = ptr_q + ADDR_W'(1);
         cnt_d   = cnt_q - CNT_W'(1);
         state_d = (cnt_q == CNT_W'(1)) ? ST_FIN : ST_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         dly_q   <= '0;
         data_q  <= '0;
         dc_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
         data_q  <= data_d;
         dc_q    <= dc_d;
         err_q   <= err_d;
      end
   end

   assign tx.tx_valid = (state_q == ST_SEND);
   assign tx.tx_data  = data_q;
   assign tx.tx_dc    = dc_q;
   assign busy        = state_q inside {ST_FETCH, ST_WAIT_ROM, ST_SEND, ST_DELAY};
   assign done        = (state_q == ST_FIN);
   assign err         = done && err_q;

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Bench for oled_cmd_sequencer: a default-table instance (DELAY_UNIT=10) and a
// single-sequence instance (NUM_SEQ=1, DELAY_UNIT=1), checked against a
// word-list timing model.
module tb_oled_cmd_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic start0, start1, rdy0, rdy1;
   logic sel0, sel1;
   logic busy0, done0, err0, busy1, done1, err1;
   bit   stall0;
   bit   mon_sel;

   always #5 clk = ~clk;

   oled_cmd_sequencer_if #(.DATA_W(8)) tx0 ();
   oled_cmd_sequencer_if #(.DATA_W(8)) tx1 ();
   assign tx0.tx_ready = rdy0;
   assign tx1.tx_ready = rdy1;

   oled_cmd_sequencer #(.ADDR_W(6), .DATA_W(8), .NUM_SEQ(2), .DELAY_UNIT(10)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .seq_sel(sel0),
      .busy(busy0), .done(done0), .err(err0), .tx(tx0)
   );

   oled_cmd_sequencer #(.ADDR_W(6), .DATA_W(8), .NUM_SEQ(1), .DELAY_UNIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .seq_sel(sel1),
      .busy(busy1), .done(done1), .err(err1), .tx(tx1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int         cyc = 0;
   logic [7:0] acc_data[$];
   logic       acc_dc[$];
   int         acc_cyc[$];
   int         done_n, done_cyc, err_done_n, err_alone_n, vld_n;
   bit         hold_pend = 0;
   logic [8:0] hold_word;

   always @(negedge clk) begin
      logic m_valid, m_ready, m_dc, m_done, m_err;
      logic [7:0] m_data;
      m_valid = mon_sel ? tx1.tx_valid : tx0.tx_valid;
      m_ready = mon_sel ? tx1.tx_ready : tx0.tx_ready;
      m_dc    = mon_sel ? tx1.tx_dc    : tx0.tx_dc;
      m_data  = mon_sel ? tx1.tx_data  : tx0.tx_data;
      m_done  = mon_sel ? done1 : done0;
      m_err   = mon_sel ? err1  : err0;
      cyc++;
      if (rst) begin
         hold_pend = 0;
      end else begin
         if (hold_pend) begin
            check_val("hold_valid", m_valid, 1);
            check_val("hold_word", {m_dc, m_data}, hold_word);
         end
         hold_pend = m_valid && !m_ready;
         hold_word = {m_dc, m_data};
         if (m_valid) vld_n++;
         if (m_valid && m_ready) begin
            acc_data.push_back(m_data);
            acc_dc.push_back(m_dc);
            acc_cyc.push_back(cyc);
         end
         if (m_done) begin
            done_n++;
            done_cyc = cyc;
            if (m_err) err_done_n++;
         end else if (m_err) begin
            err_alone_n++;
         end
      end
   end

   task automatic clear_mon();
      acc_data.delete(); acc_dc.delete(); acc_cyc.delete();
      done_n = 0; done_cyc = 0; err_done_n = 0; err_alone_n = 0; vld_n = 0;
   endtask

   // ---------------- reference model ----------------
   // Word lists straight from the panel command tables; 256+b marks a delay of b ticks.
   // Each word costs FETCH + WAIT_ROM + one more state; a delay word's last state
   // lasts max(b*du, 1) cycles. Gap = cycles between successive accepts.
   int exp_bytes[$];
   int exp_gaps[$];

   task automatic build_model(input int seq, input int du);
      int words[$];
      int pend, b;
      exp_bytes.delete(); exp_gaps.delete();
      if (seq == 0)
         words = '{'hAE, 'hD5, 'hF0, 'hA8, 'h3F, 'hD3, 'h00, 'h40, 'hA1, 'hC8, 'hDA, 'h12,
                   'h81, 'hCF, 'hD9, 'hF1, 'hDB, 'h30, 'hA4, 'hA6, 'h8D, 'h14, 'h20, 'h00,
                   256 + 100, 'hAF};
      else
         words = '{'h21, 'h00, 'h7F, 'h22, 'h00, 'h07};
      pend = 0;
      foreach (words[i]) begin
         if (words[i] >= 256) begin
            b = words[i] - 256;
            pend += 2 + ((b * du > 0) ? b * du : 1);
         end else begin
            exp_bytes.push_back(words[i]);
            exp_gaps.push_back(3 + pend);
            pend = 0;
         end
      end
   endtask

   task automatic check_stream(input string tag, input bit exact);
      int n, gap;
      check_val({tag, "_count"}, acc_data.size(), exp_bytes.size());
      n = (acc_data.size() < exp_bytes.size()) ? acc_data.size() : exp_bytes.size();
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s_byte%0d", tag, i), acc_data[i], exp_bytes[i]);
         check_val($sformatf("%s_dc%0d", tag, i), acc_dc[i], 0);
         if (i > 0) begin
            gap = acc_cyc[i] - acc_cyc[i-1];
            if (exact) check_val($sformatf("%s_gap%0d", tag, i), gap, exp_gaps[i]);
            else       check_val($sformatf("%s_mingap%0d", tag, i), gap >= exp_gaps[i], 1);
         end
      end
      if (acc_cyc.size() > 0)
         check_val({tag, "_done_lat"}, done_cyc - acc_cyc[acc_cyc.size()-1], 1);
      check_val({tag, "_done_n"}, done_n, 1);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (stall0) rdy0 = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_n == 0 && n < budget) begin
         tick();
         n++;
      end
      check_val({tag, "_in_time"}, n < budget, 1);
   endtask

   initial begin
      int n;
      rst = 1; start0 = 0; sel0 = 0; rdy0 = 0; start1 = 0; sel1 = 0; rdy1 = 1;
      stall0 = 0; mon_sel = 0;
      clear_mon();
      repeat (3) tick();

      // reset state
      check_val("rst_valid0", tx0.tx_valid, 0);
      check_val("rst_data0", tx0.tx_data, 0);
      check_val("rst_dc0", tx0.tx_dc, 0);
      check_val("rst_flags0", {busy0, done0, err0}, 0);
      check_val("rst_valid1", tx1.tx_valid, 0);
      check_val("rst_flags1", {busy1, done1, err1}, 0);
      rst = 0;
      tick();

      // window sequence, ready held high
      mon_sel = 0; rdy0 = 1; clear_mon(); build_model(1, 10);
      start0 = 1; sel0 = 1; tick(); start0 = 0;
      check_val("busy_after_start", busy0, 1);
      wait_done("win", 200);
      check_val("busy_at_end", busy0, 0);
      check_stream("win", 1);

      // init sequence with random stalls
      clear_mon(); build_model(0, 10); stall0 = 1;
      start0 = 1; sel0 = 0; tick(); start0 = 0;
      wait_done("init_stall", 6000);
      stall0 = 0; rdy0 = 1;
      check_stream("init_stall", 0);

      // start pulsed while busy is ignored
      clear_mon(); build_model(1, 10);
      start0 = 1; sel0 = 1; tick();
      for (int i = 0; i < 12; i++) begin
         start0 = (i % 3 == 0); sel0 = 0;
         tick();
      end
      start0 = 0;
      wait_done("rebusy", 200);
      repeat (30) tick();
      check_stream("rebusy", 1);

      // reset after third accepted byte
      clear_mon();
      start0 = 1; sel0 = 1; tick(); start0 = 0;
      n = 0;
      while (acc_data.size() < 3 && n < 100) begin
         tick();
         n++;
      end
      check_val("rst_mid_reached", acc_data.size(), 3);
      rst = 1; tick();
      check_val("rst_mid_valid", tx0.tx_valid, 0);
      check_val("rst_mid_data", tx0.tx_data, 0);
      check_val("rst_mid_dc", tx0.tx_dc, 0);
      check_val("rst_mid_flags", {busy0, done0, err0}, 0);
      rst = 0;
      repeat (10) tick();
      check_val("rst_mid_no_done", done_n, 0);
      clear_mon(); build_model(1, 10);
      start0 = 1; sel0 = 1; tick(); start0 = 0;
      wait_done("after_rst", 200);
      check_stream("after_rst", 1);

      // out-of-range index on the single-sequence instance
      mon_sel = 1; clear_mon();
      start1 = 1; sel1 = 1; tick(); start1 = 0;
      check_val("bad_sel_done_err", {done1, err1}, 2'b11);
      repeat (5) tick();
      check_val("bad_sel_done_n", done_n, 1);
      check_val("bad_sel_err_with_done", err_done_n, 1);
      check_val("bad_sel_err_alone", err_alone_n, 0);
      check_val("bad_sel_no_valid", vld_n, 0);

      // DELAY_UNIT=1: exact timing including the 100-tick delay word
      clear_mon(); build_model(0, 1);
      start1 = 1; sel1 = 0; tick(); start1 = 0;
      wait_done("init_du1", 600);
      check_stream("init_du1", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
